pht_ctr_update_ctrl: RTL and testbench

- Front-end controller that owns a 512x2 pattern-history SRAM macro. The macro has one read port, one masked write port and 1-cycle registered-address read latency.
- Serves prediction lookups and performs read-modify-write updates of 2-bit saturating counters.
- Clears the whole table to a programmable init value after reset.
- Sits between the BPU prediction/update pipelines and the counter SRAM; it is the only driver of the SRAM ports.

---
 rtl/pht_ctr_update_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pht_ctr_update_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pht_ctr_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pht_ctr_update_ctrl
//  Description : Front-end controller for a DEPTH x CTR_W pattern-history
//                SRAM (1R + 1 masked W, 1-cycle registered-address read).
//                After reset it sweeps every entry to INIT_VAL, then serves
//                prediction lookups and read-modify-write updates of
//                saturating counters. A one-entry write bypass makes results
//                independent of the macro's read-during-write behaviour.
//
//  Ports       : clock, reset                 - clock / sync active-high reset
//                init_done                    - table sweep complete
//                pred_req_* / pred_resp_*     - lookup request / response
//                upd_valid/idx/taken/ready    - counter update request
//                sram_r_* / sram_w_*          - SRAM macro read / write ports
//
//  Revision    : 1.0  initial release
// ============================================================================
module pht_ctr_update_ctrl #(
    parameter int DEPTH    = 512,
    parameter int IDX_W    = 9,
    parameter int CTR_W    = 2,
    parameter int INIT_VAL = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic             init_done,

    input  logic             pred_req_valid,
    input  logic [IDX_W-1:0] pred_req_idx,
    output logic             pred_req_ready,
    output logic             pred_resp_valid,
    output logic [CTR_W-1:0] pred_resp_ctr,

    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,

    output logic             sram_r_en,
    output logic [IDX_W-1:0] sram_r_addr,
    input  logic [CTR_W-1:0] sram_r_data,
    output logic             sram_w_en,
    output logic [IDX_W-1:0] sram_w_addr,
    output logic [CTR_W-1:0] sram_w_data,
    output logic             sram_w_mask
);

    localparam logic [CTR_W-1:0] C_INIT = CTR_W'(INIT_VAL);
    localparam logic [CTR_W-1:0] C_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] C_ZERO = '0;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;

    // Read issued last cycle: which requester owns the returning data.
    logic             rd_pred_q;
    logic             rd_upd_q;     // doubles as the U1 valid
    logic [IDX_W-1:0] rd_idx_q;
    logic             u1_taken_q;

    // Write issued last cycle, replayed over stale SRAM read data.
    logic             byp_valid_q;
    logic [IDX_W-1:0] byp_idx_q;
    logic [CTR_W-1:0] byp_data_q;

    // Address/data hold registers so the SRAM buses are stable while idle.
    logic [IDX_W-1:0] r_addr_q;
    logic [IDX_W-1:0] w_addr_q;
    logic [CTR_W-1:0] w_data_q;

    logic             w_run;
    logic             w_pred_fire;
    logic             w_upd_fire;
    logic [IDX_W-1:0] w_rd_idx;
    logic [CTR_W-1:0] w_rdata;
    logic [CTR_W-1:0] w_new;
    logic [IDX_W-1:0] w_wr_addr;
    logic [CTR_W-1:0] w_wr_data;

    // ------------------------------------------------------------------------
    // Handshakes and read-port arbitration. Everything is gated by reset so
    // the reset cycle itself issues no traffic, even from the RUN state.
    // ------------------------------------------------------------------------
    assign w_run          = (state_q == ST_RUN);
    assign init_done      = w_run & ~reset;
    assign pred_req_ready = init_done;
    assign upd_ready      = init_done & ~pred_req_valid;

    assign w_pred_fire    = init_done & pred_req_valid;
    assign w_upd_fire     = upd_valid & upd_ready;
    assign w_rd_idx       = pred_req_valid ? pred_req_idx : upd_idx;

    assign sram_r_en      = w_pred_fire | w_upd_fire;
    assign sram_r_addr    = sram_r_en ? w_rd_idx : r_addr_q;

    // Returning data is stale if the previous cycle wrote the same entry.
    assign w_rdata = (byp_valid_q && (byp_idx_q == rd_idx_q)) ? byp_data_q
                                                              : sram_r_data;

    assign pred_resp_valid = rd_pred_q & ~reset;
    assign pred_resp_ctr   = w_rdata;

    // ------------------------------------------------------------------------
    // U1: saturating counter update
    // ------------------------------------------------------------------------
    always_comb begin
        w_new = w_rdata;
        if (u1_taken_q) begin
            if (w_rdata != C_MAX) w_new = w_rdata + CTR_W'(1);
        end else begin
            if (w_rdata != C_ZERO) w_new = w_rdata - CTR_W'(1);
        end
    end

    // Write port: init sweep in INIT, U1 write-back in RUN (never both,
    // since reset clears U1 and U1 only fills in RUN).
    assign w_wr_addr   = w_run ? rd_idx_q : ptr_q;
    assign w_wr_data   = w_run ? w_new    : C_INIT;
    assign sram_w_en   = ~reset & (~w_run | rd_upd_q);
    assign sram_w_addr = sram_w_en ? w_wr_addr : w_addr_q;
    assign sram_w_data = sram_w_en ? w_wr_data : w_data_q;
    assign sram_w_mask = sram_w_en;

    // ------------------------------------------------------------------------
    // Control state (reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            rd_pred_q   <= 1'b0;
            rd_upd_q    <= 1'b0;
            byp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ptr_q <= ptr_q + IDX_W'(1);
                    if (ptr_q == C_LAST) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
            rd_pred_q   <= w_pred_fire;
            rd_upd_q    <= w_upd_fire;
            byp_valid_q <= sram_w_en;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers (qualified by their valids, no reset needed)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (sram_r_en) begin
            r_addr_q <= sram_r_addr;
            rd_idx_q <= w_rd_idx;
        end
        if (w_upd_fire) begin
            u1_taken_q <= upd_taken;
        end
        if (sram_w_en) begin
            w_addr_q   <= sram_w_addr;
            w_data_q   <= sram_w_data;
            byp_idx_q  <= sram_w_addr;
            byp_data_q <= sram_w_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pht_ctr_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pht_ctr_update_ctrl
//  Description : Directed self-checking bench for pht_ctr_update_ctrl with a
//                behavioural 1R1W SRAM (read returns old data on a same-cycle
//                write to the same address).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pht_ctr_update_ctrl;

    localparam int DEPTH = 512;
    localparam int IDX_W = 9;
    localparam int CTR_W = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             init_done;
    logic             pred_req_valid;
    logic [IDX_W-1:0] pred_req_idx;
    logic             pred_req_ready;
    logic             pred_resp_valid;
    logic [CTR_W-1:0] pred_resp_ctr;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;
    logic             sram_r_en;
    logic [IDX_W-1:0] sram_r_addr;
    logic [CTR_W-1:0] sram_r_data;
    logic             sram_w_en;
    logic [IDX_W-1:0] sram_w_addr;
    logic [CTR_W-1:0] sram_w_data;
    logic             sram_w_mask;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    pht_ctr_update_ctrl #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .CTR_W(CTR_W), .INIT_VAL(2)
    ) dut (
        .clock(clock), .reset(reset), .init_done(init_done),
        .pred_req_valid(pred_req_valid), .pred_req_idx(pred_req_idx),
        .pred_req_ready(pred_req_ready), .pred_resp_valid(pred_resp_valid),
        .pred_resp_ctr(pred_resp_ctr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready),
        .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
        .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data),
        .sram_w_mask(sram_w_mask)
    );

    // Behavioural SRAM: registered-address read, old data on same-cycle write.
    logic [CTR_W-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        sram_r_data = '0;
    end
    always @(posedge clock) begin
        if (sram_w_en && sram_w_mask) mem[sram_w_addr] <= sram_w_data;
        if (sram_r_en) sram_r_data <= mem[sram_r_addr];
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic predict(input logic [IDX_W-1:0] idx,
                           output logic v, output logic [CTR_W-1:0] ctr);
        pred_req_valid = 1'b1;
        pred_req_idx   = idx;
        next_cycle();
        pred_req_valid = 1'b0;
        @(negedge clock);
        v   = pred_resp_valid;
        ctr = pred_resp_ctr;
        next_cycle();
    endtask

    task automatic update_one(input logic [IDX_W-1:0] idx, input logic taken,
                              output logic we, output logic [IDX_W-1:0] wa,
                              output logic [CTR_W-1:0] wd);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        next_cycle();
        upd_valid = 1'b0;
        @(negedge clock);
        we = sram_w_en;
        wa = sram_w_addr;
        wd = sram_w_data;
        next_cycle();
    endtask

    // Checks a full sweep starting the cycle after reset release.
    task automatic run_sweep(input string tag);
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clock);
            nvec++;
            if (!(sram_w_en === 1'b1 && sram_w_addr === IDX_W'(c) && sram_w_data === 2'd2 &&
                  sram_w_mask === 1'b1 && sram_r_en === 1'b0 && init_done === 1'b0 &&
                  pred_req_ready === 1'b0 && upd_ready === 1'b0)) begin
                nerr++;
                $display("FAIL %s cycle %0d: w_en=%b addr=%0d data=%0d r_en=%b done=%b rdy=%b/%b, required w_en=1 addr=%0d data=2 done=0",
                         tag, c, sram_w_en, sram_w_addr, sram_w_data, sram_r_en, init_done,
                         pred_req_ready, upd_ready, c);
            end
            next_cycle();
        end
        @(negedge clock);
        nvec++;
        if (init_done !== 1'b1 || sram_w_en !== 1'b0 || pred_req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL %s done: init_done=%b w_en=%b ready=%b, required 1 0 1",
                     tag, init_done, sram_w_en, pred_req_ready);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pred_req_valid = 1'b0; pred_req_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            nvec++;
            if (init_done !== 1'b0 || sram_w_en !== 1'b0 || sram_r_en !== 1'b0 ||
                pred_resp_valid !== 1'b0) begin
                nerr++;
                $display("FAIL reset cycle %0d: done=%b w_en=%b r_en=%b resp=%b, required all 0",
                         k, init_done, sram_w_en, sram_r_en, pred_resp_valid);
            end
            next_cycle();
        end
        reset = 1'b0;
    endtask

    task automatic test_init_sweep();
        logic v; logic [CTR_W-1:0] ctr;
        run_sweep("init_sweep");
        predict(9'd37, v, ctr);
        nvec++;
        if (v !== 1'b1 || ctr !== 2'd2) begin
            nerr++;
            $display("FAIL init_lookup37: valid=%b ctr=%0d, required 1 2", v, ctr);
        end
    endtask

    task automatic test_saturation();
        logic we, v; logic [IDX_W-1:0] wa; logic [CTR_W-1:0] wd, ctr;
        logic       taken_tbl [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0] exp_tbl   [8] = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        for (int k = 0; k < 8; k++) begin
            update_one(9'd5, taken_tbl[k], we, wa, wd);
            nvec++;
            if (we !== 1'b1 || wa !== 9'd5 || wd !== exp_tbl[k]) begin
                nerr++;
                $display("FAIL sat_write step %0d: w_en=%b addr=%0d data=%0d, required 1 5 %0d",
                         k, we, wa, wd, exp_tbl[k]);
            end
            predict(9'd5, v, ctr);
            nvec++;
            if (v !== 1'b1 || ctr !== exp_tbl[k]) begin
                nerr++;
                $display("FAIL sat_lookup step %0d: valid=%b ctr=%0d, required 1 %0d",
                         k, v, ctr, exp_tbl[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic v; logic [CTR_W-1:0] ctr;
        logic       taken_tbl [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] exp_tbl   [3] = '{2'd3, 2'd3, 2'd2};
        for (int k = 0; k < 4; k++) begin
            upd_valid = (k < 3);
            upd_idx   = 9'd100;
            upd_taken = (k < 3) ? taken_tbl[k] : 1'b0;
            @(negedge clock);
            nvec++;
            if (k < 3 && upd_ready !== 1'b1) begin
                nerr++;
                $display("FAIL b2b_ready cycle %0d: upd_ready=%b, required 1", k, upd_ready);
            end
            if (k > 0 && (sram_w_en !== 1'b1 || sram_w_addr !== 9'd100 ||
                          sram_w_data !== exp_tbl[k-1])) begin
                nerr++;
                $display("FAIL b2b_write %0d: w_en=%b addr=%0d data=%0d, required 1 100 %0d",
                         k - 1, sram_w_en, sram_w_addr, sram_w_data, exp_tbl[k-1]);
            end
            next_cycle();
        end
        upd_valid = 1'b0;
        @(negedge clock);
        nvec++;
        if (sram_w_en !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_idle: w_en=%b, required 0", sram_w_en);
        end
        next_cycle();
        predict(9'd100, v, ctr);
        nvec++;
        if (v !== 1'b1 || ctr !== 2'd2) begin
            nerr++;
            $display("FAIL b2b_lookup: valid=%b ctr=%0d, required 1 2", v, ctr);
        end
    endtask

    task automatic test_arbitration();
        logic v; logic [CTR_W-1:0] ctr;
        upd_valid = 1'b1; upd_idx = 9'd200; upd_taken = 1'b1;
        pred_req_valid = 1'b1; pred_req_idx = 9'd37;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            nvec++;
            if (upd_ready !== 1'b0 || sram_w_en !== 1'b0 || sram_r_en !== 1'b1 ||
                sram_r_addr !== 9'd37) begin
                nerr++;
                $display("FAIL arb_stall cycle %0d: upd_ready=%b w_en=%b r_en=%b r_addr=%0d, required 0 0 1 37",
                         k, upd_ready, sram_w_en, sram_r_en, sram_r_addr);
            end
            if (k > 0 && (pred_resp_valid !== 1'b1 || pred_resp_ctr !== 2'd2)) begin
                nerr++;
                $display("FAIL arb_resp cycle %0d: valid=%b ctr=%0d, required 1 2",
                         k, pred_resp_valid, pred_resp_ctr);
            end
            next_cycle();
        end
        pred_req_valid = 1'b0;
        @(negedge clock);
        nvec++;
        if (upd_ready !== 1'b1 || sram_r_addr !== 9'd200 || sram_w_en !== 1'b0 ||
            pred_resp_valid !== 1'b1) begin
            nerr++;
            $display("FAIL arb_accept: upd_ready=%b r_addr=%0d w_en=%b resp=%b, required 1 200 0 1",
                     upd_ready, sram_r_addr, sram_w_en, pred_resp_valid);
        end
        next_cycle();
        upd_valid = 1'b0;
        @(negedge clock);
        nvec++;
        if (sram_w_en !== 1'b1 || sram_w_addr !== 9'd200 || sram_w_data !== 2'd3) begin
            nerr++;
            $display("FAIL arb_write: w_en=%b addr=%0d data=%0d, required 1 200 3",
                     sram_w_en, sram_w_addr, sram_w_data);
        end
        next_cycle();
        predict(9'd200, v, ctr);
        nvec++;
        if (v !== 1'b1 || ctr !== 2'd3) begin
            nerr++;
            $display("FAIL arb_lookup: valid=%b ctr=%0d, required 1 3", v, ctr);
        end
    endtask

    task automatic test_same_cycle_hazard();
        // Update idx 7 at t, lookup idx 7 at t+1 (read collides with write).
        upd_valid = 1'b1; upd_idx = 9'd7; upd_taken = 1'b1;
        next_cycle();
        upd_valid = 1'b0;
        pred_req_valid = 1'b1; pred_req_idx = 9'd7;
        @(negedge clock);
        nvec++;
        if (sram_w_en !== 1'b1 || sram_w_addr !== 9'd7 || sram_w_data !== 2'd3 ||
            sram_r_en !== 1'b1 || sram_r_addr !== 9'd7) begin
            nerr++;
            $display("FAIL hazard_collide: w_en=%b waddr=%0d wdata=%0d r_en=%b raddr=%0d, required 1 7 3 1 7",
                     sram_w_en, sram_w_addr, sram_w_data, sram_r_en, sram_r_addr);
        end
        next_cycle();
        pred_req_valid = 1'b0;
        @(negedge clock);
        nvec++;
        if (pred_resp_valid !== 1'b1 || pred_resp_ctr !== 2'd3) begin
            nerr++;
            $display("FAIL hazard_bypass: valid=%b ctr=%0d, required 1 3",
                     pred_resp_valid, pred_resp_ctr);
        end
        next_cycle();
        // Lookup and update of idx 8 together: lookup wins and sees the old value.
        pred_req_valid = 1'b1; pred_req_idx = 9'd8;
        upd_valid = 1'b1; upd_idx = 9'd8; upd_taken = 1'b1;
        next_cycle();
        pred_req_valid = 1'b0;
        @(negedge clock);
        nvec++;
        if (pred_resp_valid !== 1'b1 || pred_resp_ctr !== 2'd2 || upd_ready !== 1'b1) begin
            nerr++;
            $display("FAIL hazard_old: valid=%b ctr=%0d upd_ready=%b, required 1 2 1",
                     pred_resp_valid, pred_resp_ctr, upd_ready);
        end
        next_cycle();
        upd_valid = 1'b0;
        @(negedge clock);
        nvec++;
        if (sram_w_en !== 1'b1 || sram_w_addr !== 9'd8 || sram_w_data !== 2'd3) begin
            nerr++;
            $display("FAIL hazard_late_write: w_en=%b addr=%0d data=%0d, required 1 8 3",
                     sram_w_en, sram_w_addr, sram_w_data);
        end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        logic v; logic [CTR_W-1:0] ctr;
        // Reset while the sweep pointer is at 200.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 200; c++) next_cycle();
        reset = 1'b1;
        @(negedge clock);
        nvec++;
        if (sram_w_en !== 1'b0 || init_done !== 1'b0) begin
            nerr++;
            $display("FAIL midsweep_reset: w_en=%b done=%b, required 0 0", sram_w_en, init_done);
        end
        next_cycle();
        reset = 1'b0;
        run_sweep("resweep");
        // Reset while an update sits in U1.
        upd_valid = 1'b1; upd_idx = 9'd9; upd_taken = 1'b1;
        next_cycle();
        upd_valid = 1'b0;
        reset = 1'b1;
        pred_req_valid = 1'b1; pred_req_idx = 9'd9;
        @(negedge clock);
        nvec++;
        if (sram_w_en !== 1'b0 || sram_r_en !== 1'b0 || init_done !== 1'b0 ||
            pred_resp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL u1_reset: w_en=%b r_en=%b done=%b resp=%b, required 0 0 0 0",
                     sram_w_en, sram_r_en, init_done, pred_resp_valid);
        end
        next_cycle();
        reset = 1'b0;
        pred_req_valid = 1'b0;
        run_sweep("u1_resweep");
        predict(9'd9, v, ctr);
        nvec++;
        if (v !== 1'b1 || ctr !== 2'd2) begin
            nerr++;
            $display("FAIL u1_lookup: valid=%b ctr=%0d, required 1 2", v, ctr);
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_saturation();
        test_back_to_back();
        test_arbitration();
        test_same_cycle_hazard();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
